// File: rtl/sc_pkg.sv
// Shared definitions for the Simple Computer: default widths and sequencer state codes.
package sc_pkg;

    localparam int SC_ADDR_WIDTH = 6;
    localparam int SC_CNT_WIDTH  = 16;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t S_IDLE      = 3'd0;
    localparam seq_state_t S_RUN       = 3'd1;
    localparam seq_state_t S_WAIT_STEP = 3'd2;
    localparam seq_state_t S_EXEC_ONE  = 3'd3;
    localparam seq_state_t S_HALTED    = 3'd4;

endpackage

// File: rtl/rise_edge_detect.sv
// One-cycle pulse on the rising edge of a debounced front-panel level.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d;
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC and execution sequencer: free-run / single-step / halt, next-PC select, commit counter.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | one cycle after reset, picks run or step mode
//   RUN       | free-run, one commit per cycle
//   WAIT_STEP | step mode, waiting for a step button edge (no commit)
//   EXEC_ONE  | step mode, commits exactly one instruction
//   HALTED    | HALT committed; pc and counter frozen until reset
module fetch_sequencer
    import sc_pkg::*;
#(
    parameter int ADDR_WIDTH = SC_ADDR_WIDTH,
    parameter int CNT_WIDTH  = SC_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  step,
    input  logic                  halt_instr,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  branch_en,
    input  logic [ADDR_WIDTH-1:0] branch_off,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  exec_en,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  instr_count
);

    seq_state_t            state;
    seq_state_t            state_nxt;
    logic                  step_rise;
    logic [ADDR_WIDTH-1:0] pc_nxt;

    rise_edge_detect u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (step),
        .pulse (step_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = run ? S_RUN : S_WAIT_STEP;
            S_RUN: begin
                if (halt_instr) state_nxt = S_HALTED;
                else if (!run)  state_nxt = S_WAIT_STEP;
            end
            S_WAIT_STEP: begin
                if (run)            state_nxt = S_RUN;
                else if (step_rise) state_nxt = S_EXEC_ONE;
            end
            S_EXEC_ONE: begin
                if (halt_instr) state_nxt = S_HALTED;
                else if (run)   state_nxt = S_RUN;
                else            state_nxt = S_WAIT_STEP;
            end
            S_HALTED:    state_nxt = S_HALTED;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        exec_en = (state == S_RUN) || (state == S_EXEC_ONE);
        halted  = (state == S_HALTED);
    end

    // Branch offset is two's complement, so a plain modulo add gives pc - |off| too.
    always_comb begin
        pc_nxt = pc;
        if (exec_en && !halt_instr) begin
            if (jump_en)        pc_nxt = jump_addr;
            else if (branch_en) pc_nxt = pc + branch_off;
            else                pc_nxt = pc + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pc <= '0;
        else      pc <= pc_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            instr_count <= '0;
        else if (exec_en && (instr_count != {CNT_WIDTH{1'b1}}))
            instr_count <= instr_count + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: behavioural model compared every cycle plus literal checkpoints.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b1;
    logic       step = 1'b0;
    logic       halt_instr = 1'b0;
    logic       jump_en = 1'b0;
    logic [5:0] jump_addr = 6'd0;
    logic       branch_en = 1'b0;
    logic [5:0] branch_off = 6'd0;

    logic [5:0]  pc_a, pc_b;
    logic        ex_a, ex_b, hl_a, hl_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.ADDR_WIDTH(6), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_instr(halt_instr),
        .jump_en(jump_en), .jump_addr(jump_addr), .branch_en(branch_en),
        .branch_off(branch_off), .pc(pc_a), .exec_en(ex_a), .halted(hl_a),
        .instr_count(cnt_a)
    );

    fetch_sequencer #(.ADDR_WIDTH(6), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_instr(halt_instr),
        .jump_en(jump_en), .jump_addr(jump_addr), .branch_en(branch_en),
        .branch_off(branch_off), .pc(pc_b), .exec_en(ex_b), .halted(hl_b),
        .instr_count(cnt_b)
    );

    always #5 clk = ~clk;

    // Model: "commits this cycle", "halted", "first cycle after reset", pc and commit total.
    logic [5:0] m_pc = 6'd0;
    int         m_cnt = 0;
    bit         m_commit = 1'b0;
    bit         m_halted = 1'b0;
    bit         m_fresh = 1'b1;
    bit         m_prev_step = 1'b0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        automatic logic [5:0] npc = m_pc;
        automatic int         ncnt = m_cnt;
        automatic bit         ncommit = m_commit;
        automatic bit         nhalt = m_halted;
        automatic bit         nfresh = m_fresh;
        automatic bit         rise = step && !m_prev_step;
        if (!rst) begin
            npc = 6'd0; ncnt = 0; ncommit = 1'b0; nhalt = 1'b0; nfresh = 1'b1;
        end else if (m_halted) begin
            nhalt = 1'b1;
        end else if (m_commit) begin
            ncnt = m_cnt + 1;
            if (halt_instr) begin
                nhalt = 1'b1;
                ncommit = 1'b0;
            end else begin
                ncommit = run;
                if (jump_en)        npc = jump_addr;
                else if (branch_en) npc = 6'(m_pc + branch_off);
                else                npc = 6'(m_pc + 6'd1);
            end
        end else begin
            ncommit = m_fresh ? run : (run || rise);
            nfresh = 1'b0;
        end
        m_pc        <= npc;
        m_cnt       <= ncnt;
        m_commit    <= ncommit;
        m_halted    <= nhalt;
        m_fresh     <= nfresh;
        m_prev_step <= rst ? step : 1'b0;
        m_valid     <= m_valid || !rst;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pc", 32'(pc_a), 32'(m_pc));
            chk("exec_en", 32'(ex_a), 32'(m_commit));
            chk("halted", 32'(hl_a), 32'(m_halted));
            chk("instr_count", 32'(cnt_a), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
            chk("pc_w4", 32'(pc_b), 32'(m_pc));
            chk("exec_en_w4", 32'(ex_b), 32'(m_commit));
            chk("halted_w4", 32'(hl_b), 32'(m_halted));
            chk("instr_count_w4", 32'(cnt_b), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pc(input logic [5:0] p);
        for (int i = 0; i < 300; i++) begin
            if (m_commit && m_pc == p) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL wait_pc: pc %0h never reached, model pc %0h", p, m_pc);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    initial begin
        // Free-run from reset, full wrap, counter saturation on the 4-bit instance
        tick(2);
        rst = 1'b1;
        chk("lit_idle_exec", 32'(ex_a), 32'd0);
        tick(1);
        chk("lit_first_exec", 32'(ex_a), 32'd1);
        chk("lit_first_pc", 32'(pc_a), 32'd0);
        for (int i = 0; i < 200 && m_cnt != 64; i++) tick(1);
        chk("lit_wrap_pc", 32'(pc_a), 32'd0);
        chk("lit_cnt64", 32'(cnt_a), 32'd64);
        chk("lit_cnt_sat", 32'(cnt_b), 32'd15);

        // Reset mid-run
        wait_pc(6'd12);
        rst = 1'b0;
        tick(1);
        chk("lit_rst_pc", 32'(pc_a), 32'd0);
        chk("lit_rst_exec", 32'(ex_a), 32'd0);
        chk("lit_rst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b1;

        // Jump, negative branch, jump beats branch
        wait_pc(6'd5);
        jump_en = 1'b1; jump_addr = 6'h20;
        tick(1);
        jump_en = 1'b0;
        chk("lit_jump", 32'(pc_a), 32'h20);
        branch_en = 1'b1; branch_off = 6'h3E;
        tick(1);
        branch_en = 1'b0;
        chk("lit_branch", 32'(pc_a), 32'h1E);
        jump_en = 1'b1; jump_addr = 6'h10; branch_en = 1'b1; branch_off = 6'h05;
        tick(1);
        jump_en = 1'b0; branch_en = 1'b0;
        chk("lit_jump_prio", 32'(pc_a), 32'h10);

        // Mode switch, HALT ignored while waiting for a step
        do_reset();
        wait_pc(6'd4);
        run = 1'b0;
        tick(1);
        chk("lit_stop_exec", 32'(ex_a), 32'd0);
        chk("lit_stop_pc", 32'(pc_a), 32'd5);
        halt_instr = 1'b1;
        tick(3);
        chk("lit_wait_nohalt", 32'(hl_a), 32'd0);
        chk("lit_wait_pc", 32'(pc_a), 32'd5);
        halt_instr = 1'b0;
        run = 1'b1;
        tick(1);
        chk("lit_resume_exec", 32'(ex_a), 32'd1);
        chk("lit_resume_pc", 32'(pc_a), 32'd5);

        // Single-step with held button levels
        run = 1'b0;
        do_reset();
        tick(3);
        step = 1'b1; tick(3);
        step = 1'b0; tick(3);
        step = 1'b1; tick(3);
        step = 1'b0; tick(3);
        chk("lit_step_pc", 32'(pc_a), 32'd2);
        chk("lit_step_cnt", 32'(cnt_a), 32'd2);

        // Halt is terminal until reset
        run = 1'b1;
        do_reset();
        wait_pc(6'd9);
        halt_instr = 1'b1;
        tick(1);
        halt_instr = 1'b0;
        chk("lit_halted", 32'(hl_a), 32'd1);
        chk("lit_halt_exec", 32'(ex_a), 32'd0);
        chk("lit_halt_pc", 32'(pc_a), 32'd9);
        chk("lit_halt_cnt", 32'(cnt_a), 32'd10);
        step = 1'b1; tick(2);
        step = 1'b0; run = 1'b0; tick(2);
        run = 1'b1; tick(2);
        chk("lit_halt_hold_pc", 32'(pc_a), 32'd9);
        chk("lit_halt_hold", 32'(hl_a), 32'd1);
        chk("lit_halt_hold_cnt", 32'(cnt_a), 32'd10);
        do_reset();
        chk("lit_unhalt", 32'(hl_a), 32'd0);
        chk("lit_unhalt_pc", 32'(pc_a), 32'd0);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and execution sequencer for the single-cycle Simple Computer.
- Drives the instruction ROM address every cycle; the ROM is combinational, so the instruction for `pc` is valid in the same cycle.
- Generates `exec_en`, which qualifies every architectural state update in the datapath (register file and data memory writes).
- Supports free-run, single-step (button) and halt, and computes the next PC from sequential, branch and jump requests.

Parameters:
- ADDR_WIDTH, 6: PC and ROM address width; program space is 2**ADDR_WIDTH words.
- CNT_WIDTH, 16: width of the executed-instruction counter.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- run  in  1  level: 1 = free-run mode, 0 = single-step mode.
- step  in  1  debounced step button (level); only its rising edge is used.
- halt_instr  in  1  from decoder: the current instruction is HALT.
- jump_en  in  1  from decoder: absolute jump.
- jump_addr  in  ADDR_WIDTH  jump target.
- branch_en  in  1  from decoder/ALU: branch taken.
- branch_off  in  ADDR_WIDTH  two's-complement offset, relative to the current pc.
- pc  out  ADDR_WIDTH  instruction ROM address.
- exec_en  out  1  current instruction commits this cycle.
- halted  out  1  sequencer is in HALTED.
- instr_count  out  CNT_WIDTH  number of committed instructions, saturating.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, pc=0, instr_count=0, step_q=0.
  - Outputs: exec_en=0, halted=0.
  - Reset overrides everything, including mid-RUN and HALTED.
- States (Moore): IDLE, RUN, WAIT_STEP, EXEC_ONE, HALTED.
  - exec_en=1 only in RUN and EXEC_ONE.
  - halted=1 only in HALTED.
  - Both are decoded from registered state, with no input-to-output combinational path.
- Step edge: step_q <= step every cycle; step_rise = step & ~step_q.
- Transitions:
  - IDLE: run=1 -> RUN; otherwise -> WAIT_STEP. IDLE always lasts exactly one cycle after reset.
  - RUN: halt_instr -> HALTED; else run=0 -> WAIT_STEP; else stay in RUN. The instruction in the cycle where run drops still commits.
  - WAIT_STEP: halt_instr is ignored (no commit). run=1 -> RUN; else step_rise -> EXEC_ONE; else stay.
  - EXEC_ONE: lasts exactly one cycle. halt_instr -> HALTED; else run=1 -> RUN; else -> WAIT_STEP.
  - HALTED: terminal; left only by reset. pc and instr_count are frozen.
  - step_rise in RUN, EXEC_ONE or HALTED is discarded, not queued.
- Next PC, evaluated only when exec_en=1; otherwise pc holds. Priority, highest first:
  1. halt_instr: pc unchanged.
  2. jump_en: pc <= jump_addr.
  3. branch_en: pc <= pc + branch_off.
  4. Otherwise: pc <= pc + 1.
- PC arithmetic:
  - All adds are modulo 2**ADDR_WIDTH; wrap-around is silent. Example: pc=63, +1 -> 0.
  - branch_off is sign-interpreted; for ADDR_WIDTH=6, 6'h3F = -1.
  - Simultaneous jump_en and branch_en: the jump wins.
- instr_count:
  - Increments by 1 on every exec_en=1 cycle, including the HALT instruction itself.
  - Saturates at all-ones; it never wraps.
- Latency:
  - From reset release, the first commit at pc=0 happens in cycle 2 when run=1 (cycle 1 is IDLE).
  - From step_rise in WAIT_STEP, the commit happens in the following cycle.

Decomposition:
- Shared package `sc_pkg`:
  - State encoding localparams: S_IDLE=3'd0, S_RUN=3'd1, S_WAIT_STEP=3'd2, S_EXEC_ONE=3'd3, S_HALTED=3'd4.
  - Default ADDR_WIDTH and CNT_WIDTH constants, shared with instruction_rom and the decoder.
- One sub-module: `rise_edge_detect` (clk, rst, d -> pulse), a single register with synchronous active-low reset, reused later for other front-panel buttons.
- The FSM, PC register/next-PC mux and counter stay in fetch_sequencer.

Test Plan:
- Free-run: rst low 2 cycles then high, run=1, no control inputs.
  - Required: exec_en=0 in the first cycle after release; then pc = 0,1,2,... one per cycle.
  - Required: pc wraps 63 -> 0; instr_count = 64 after 64 commits.
- Single-step: run=0, step pulsed high for 3 cycles, twice.
  - Required: exactly one exec_en cycle per pulse (held level does not repeat); pc 0 -> 1 -> 2; instr_count=2.
- Control flow:
  - At pc=5: jump_en=1, jump_addr=6'h20 -> pc=0x20.
  - At pc=0x20: branch_en=1, branch_off=6'h3E (-2) -> pc=0x1E.
  - jump_en and branch_en together -> jump target taken.
- Halt:
  - halt_instr=1 at pc=9 in RUN -> next cycle halted=1, exec_en=0, pc stays 9, instr_count includes the HALT.
  - step pulses and run toggles afterwards have no effect.
  - rst=0 returns pc=0, halted=0.
- Mode switch:
  - run 1 -> 0 at pc=4 -> instruction 4 commits, state WAIT_STEP, pc=5 holds.
  - Then run=1 -> resumes at pc=5 next cycle.
  - halt_instr=1 in WAIT_STEP with no step -> no transition to HALTED.
- Counter saturation and reset mid-run:
  - With CNT_WIDTH=4, 20 commits -> instr_count sticks at 15.
  - rst=0 mid-RUN at pc=12 -> next cycle pc=0, exec_en=0, instr_count=0.
